// File: rtl/arb_pkg.sv
// Shared definitions for the parametrised arbiter: mode codes, FSM states and
// a constant-function clog2 for tools lacking $clog2.
package arb_pkg;

  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    int x;
    r = 0;
    x = value - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_rot_pick.sv
// Combinational rotating first-one picker: finds the first set request at or
// above 'start', wrapping to the lowest set request when none is found above.
module arb_rot_pick
  import arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] hi_req;
  logic [N-1:0] sel_req;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign hi_mask[gi] = (IDW'(gi) >= start);
    end
  endgenerate

  // Requests at/after start take precedence; otherwise wrap around to index 0.
  assign hi_req  = req & hi_mask;
  assign sel_req = (|hi_req) ? hi_req : req;
  assign any     = |req;

  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel_req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/param_rr_priority_arbiter.sv
// N-way arbiter with runtime fixed/round-robin mode, grant hold while the
// owner keeps requesting, and an RR hold limit to prevent starvation.
module param_rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8,
  localparam int IDW     = clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grnt,
  output logic           grnt_valid,
  output logic [IDW-1:0] grnt_id
);

  localparam int             HCW      = clog2(HOLD_MAX + 1);
  localparam logic [HCW-1:0] HOLD_LIM = HCW'(HOLD_MAX - 1);
  localparam logic [HCW-1:0] HOLD_SAT = HCW'(HOLD_MAX);
  localparam logic [IDW-1:0] PTR_TOP  = IDW'(N - 1);

  arb_state_e     state_q;
  logic [N-1:0]   grnt_q;
  logic           grnt_valid_q;
  logic [IDW-1:0] grnt_id_q;
  logic [HCW-1:0] hold_cnt_q;
  logic [IDW-1:0] rr_ptr_q;

  logic [IDW-1:0] start_d;
  logic [N-1:0]   pick_onehot;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic           owner_req;
  logic           keep_owner;

  always_comb begin
    start_d = '0;
    if (mode == ARB_MODE_RR) begin
      start_d = (rr_ptr_q == PTR_TOP) ? '0 : rr_ptr_q + IDW'(1);
    end
  end

  arb_rot_pick #(
    .N  (N),
    .IDW(IDW)
  ) u_pick (
    .req   (req),
    .start (start_d),
    .onehot(pick_onehot),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // The owner keeps the grant unless it drops its request or hits the RR limit;
  // hold_cnt keeps counting in fixed mode so a later switch to RR can force a handover.
  assign owner_req  = |(req & grnt_q);
  assign keep_owner = (state_q == ARB_GRANT) && owner_req &&
                      ((mode == ARB_MODE_FIXED) || (hold_cnt_q < HOLD_LIM));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grnt_q       <= '0;
      grnt_valid_q <= 1'b0;
      grnt_id_q    <= '0;
      hold_cnt_q   <= '0;
      rr_ptr_q     <= PTR_TOP;
    end else if (keep_owner) begin
      if (hold_cnt_q != HOLD_SAT) begin
        hold_cnt_q <= hold_cnt_q + HCW'(1);
      end
    end else if (pick_any) begin
      state_q      <= ARB_GRANT;
      grnt_q       <= pick_onehot;
      grnt_valid_q <= 1'b1;
      grnt_id_q    <= pick_idx;
      hold_cnt_q   <= '0;
      rr_ptr_q     <= pick_idx;
    end else begin
      state_q      <= ARB_IDLE;
      grnt_q       <= '0;
      grnt_valid_q <= 1'b0;
      grnt_id_q    <= '0;
      hold_cnt_q   <= '0;
    end
  end

  assign grnt       = grnt_q;
  assign grnt_valid = grnt_valid_q;
  assign grnt_id    = grnt_id_q;

endmodule
